serv_decode_q: RTL

- Parametrised successor to the single-entry instruction decoder: a DEPTH-entry queue of pre-extracted instruction fields with valid/ready handshakes.
- The head entry is decoded combinationally into control signals for state/ALU/bufreg/ctrl.
- Adds flush, debug-halt ebreak injection, illegal-opcode flagging and an optional CSR decode mode.
- Sits between the ibus fetch interface and the serial core state machine.

---
 rtl/serv_decode_q_if.sv | 45 ++++
 rtl/serv_decode_q.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serv_decode_q_if.sv
// Handshake and decode bundle between the fetch side, the decode queue and the
// serial core. The fetch/core side uses the master view; the queue uses the slave view.
interface serv_decode_q_if #(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [29:0]      i_wb_rdt;
    logic             i_wb_en;
    logic             o_ready;
    logic             i_adv;
    logic             i_flush;
    logic             i_dbg_halt;
    logic             o_valid;
    logic [CNT_W-1:0] o_count;
    logic [4:0]       o_opcode;
    logic [2:0]       o_funct3;
    logic             o_rd_op;
    logic             o_two_stage_op;
    logic             o_dbus_en;
    logic             o_branch_op;
    logic             o_shift_op;
    logic             o_alu_sub;
    logic             o_ebreak;
    logic             o_e_op;
    logic             o_mret;
    logic             o_illegal;
    logic             o_csr_en;
    logic [2:0]       o_csr_addr;
    logic             o_dbg_inj;

    modport master (
        output i_wb_rdt, i_wb_en, i_adv, i_flush, i_dbg_halt,
        input  o_ready, o_valid, o_count, o_opcode, o_funct3, o_rd_op,
               o_two_stage_op, o_dbus_en, o_branch_op, o_shift_op, o_alu_sub,
               o_ebreak, o_e_op, o_mret, o_illegal, o_csr_en, o_csr_addr, o_dbg_inj
    );

    modport slave (
        input  i_wb_rdt, i_wb_en, i_adv, i_flush, i_dbg_halt,
        output o_ready, o_valid, o_count, o_opcode, o_funct3, o_rd_op,
               o_two_stage_op, o_dbus_en, o_branch_op, o_shift_op, o_alu_sub,
               o_ebreak, o_e_op, o_mret, o_illegal, o_csr_en, o_csr_addr, o_dbg_inj
    );
endinterface

// File: rtl/serv_decode_q.sv
// DEPTH-entry queue of pre-extracted instruction fields. The head entry is
// decoded combinationally into serial-core control signals (NOP when empty).
module serv_decode_q #(
    parameter int DEPTH    = 2,
    parameter int WITH_CSR = 1
) (
    input logic            clk,
    input logic            i_rst,
    serv_decode_q_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] funct3;
        logic       imm30;
        logic       op20;
        logic       op21;
        logic       op22;
        logic       op26;
        logic       op27;
        logic       dbg;
    } entry_t;

    localparam entry_t NOP_ENTRY = '{opcode: 5'b00100, default: '0};

    entry_t mem_q [DEPTH];
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    cnt_t   count_q, count_d;

    logic   ready_w, valid_w, push_w, pop_w;
    entry_t entry_w, head_w;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
    endfunction

    assign ready_w = (count_q != FULL_CNT);
    assign valid_w = (count_q != '0);
    assign push_w  = bus.i_wb_en & ready_w;
    assign pop_w   = bus.i_adv & valid_w;

    // Only bits [31:2] that feed stored fields are used; the rest never matter.
    logic unused_rdt;
    assign unused_rdt = ^{bus.i_wb_rdt[29], bus.i_wb_rdt[27:26], bus.i_wb_rdt[23:21],
                          bus.i_wb_rdt[17:13], bus.i_wb_rdt[9:5]};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        entry_w = '0;
        if (bus.i_dbg_halt) begin
            entry_w.opcode = 5'b11100;
            entry_w.op20   = 1'b1;
            entry_w.dbg    = 1'b1;
        end else begin
            entry_w.opcode = bus.i_wb_rdt[4:0];
            entry_w.funct3 = bus.i_wb_rdt[12:10];
            entry_w.imm30  = bus.i_wb_rdt[28];
            entry_w.op20   = bus.i_wb_rdt[18];
            entry_w.op21   = bus.i_wb_rdt[19];
            entry_w.op22   = bus.i_wb_rdt[20];
            entry_w.op26   = bus.i_wb_rdt[24];
            entry_w.op27   = bus.i_wb_rdt[25];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_w)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; count_q alone says which slots hold live data.
    always_ff @(posedge clk) begin
        if (push_w && !bus.i_flush) mem_q[wr_ptr_q] <= entry_w;
    end

    assign head_w = valid_w ? mem_q[rd_ptr_q] : NOP_ENTRY;

    logic [4:0] op;
    logic [2:0] f3;
    logic       csr_op, csr_valid;
    assign op = head_w.opcode;
    assign f3 = head_w.funct3;

    always_comb begin
        bus.o_two_stage_op = ~op[2] | (f3[0] & ~f3[1] & ~op[0] & ~op[4])
                                    | (f3[1] & ~f3[2] & ~op[0] & ~op[4]);
        bus.o_shift_op     = op[2] & ~f3[1];
        bus.o_dbus_en      = ~op[2] & ~op[4];
        bus.o_rd_op        = op[2] | (~op[2] & op[4] & op[0]) | (~op[2] & ~op[3] & ~op[0]);
        bus.o_alu_sub      = f3[1] | f3[0] | (op[3] & head_w.imm30) | op[4];
        bus.o_ebreak       = head_w.op20 & (op == 5'b11100) & (f3 == 3'b000);
        bus.o_e_op         = op[4] & op[2] & ~head_w.op21 & ~|f3;
        bus.o_mret         = op[4] & op[2] & head_w.op21 & ~|f3;
        bus.o_branch_op    = op[4];
        case (op)
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: bus.o_illegal = 1'b0;
            default:                                          bus.o_illegal = 1'b1;
        endcase
    end

    assign csr_op    = op[4] & op[2] & |f3;
    assign csr_valid = (head_w.imm30 & (head_w.op21 | head_w.op20))
                     | ((head_w.op26 | head_w.op22) & head_w.op20)
                     | (head_w.op26 & ~(head_w.op22 | head_w.op21));

    assign bus.o_csr_en   = (WITH_CSR != 0) & csr_op & csr_valid;
    assign bus.o_csr_addr = (WITH_CSR != 0)
                          ? {head_w.op27, head_w.op22 | head_w.op21, ~head_w.op21 & head_w.op20}
                          : 3'b000;

    assign bus.o_ready   = ready_w;
    assign bus.o_valid   = valid_w;
    assign bus.o_count   = count_q;
    assign bus.o_opcode  = op;
    assign bus.o_funct3  = f3;
    assign bus.o_dbg_inj = head_w.dbg;
endmodule
